// File: rtl/uart_rx_fifo.sv
// 8N1 UART receiver: two-flop synchronizer, mid-bit sampling FSM and a
// first-word-fall-through byte FIFO with sticky framing/overrun flags.
module uart_rx_fifo #(
   parameter int CLK_PER_BIT = 868,
   parameter int FIFO_WIDTH  = 4
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic       UART_RX,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_pop,
   output logic       frame_err,
   output logic       overrun,
   input  logic       clr_err
);

   localparam int CNT_W = $clog2(CLK_PER_BIT);
   localparam int DEPTH = 2 ** FIFO_WIDTH;
   localparam logic [CNT_W-1:0]    CNT_FULL = CNT_W'(CLK_PER_BIT - 1);
   localparam logic [CNT_W-1:0]    CNT_HALF = CNT_W'(CLK_PER_BIT / 2 - 1);
   localparam logic [FIFO_WIDTH:0] CNT_MAX  = (FIFO_WIDTH + 1)'(DEPTH);

   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BREAK} state_t;

   logic                  r_sync1, r_sync2;
   state_t                r_state;
   logic [CNT_W-1:0]      r_cnt;
   logic [2:0]            r_bit_idx;
   logic [7:0]            r_shift;
   logic                  r_push;
   logic [7:0]            r_push_data;
   logic                  r_frame_err;
   logic [7:0]            r_mem [DEPTH];
   logic [FIFO_WIDTH-1:0] r_wr_ptr, r_rd_ptr;
   logic [FIFO_WIDTH:0]   r_count;
   logic                  r_overrun;

   logic w_rx_s, w_cnt_zero, w_full, w_pop, w_wr;

   assign w_rx_s     = r_sync2;
   assign w_cnt_zero = (r_cnt == '0);

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
      end else begin
         r_sync1 <= UART_RX;
         r_sync2 <= r_sync1;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state     <= S_IDLE;
         r_cnt       <= '0;
         r_bit_idx   <= '0;
         r_shift     <= '0;
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_push <= 1'b0;
         // NOTE: non-blocking assignments resolve last-wins, so the framing-error
         // set further down overrides this clear in the same cycle.
         if (clr_err) r_frame_err <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (!w_rx_s) begin
                  r_state <= S_START;
                  r_cnt   <= CNT_HALF;
               end
            end
            S_START: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (w_rx_s) begin
                  r_state <= S_IDLE;
               end else begin
                  r_state   <= S_DATA;
                  r_cnt     <= CNT_FULL;
                  r_bit_idx <= '0;
               end
            end
            S_DATA: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else begin
                  r_shift[r_bit_idx] <= w_rx_s;
                  r_cnt              <= CNT_FULL;
                  r_bit_idx          <= r_bit_idx + 3'd1;
                  if (r_bit_idx == 3'd7) r_state <= S_STOP;
               end
            end
            S_STOP: begin
               if (!w_cnt_zero) begin
                  r_cnt <= r_cnt - 1'b1;
               end else if (w_rx_s) begin
                  r_push      <= 1'b1;
                  r_push_data <= r_shift;
                  r_state     <= S_IDLE;
               end else begin
                  r_frame_err <= 1'b1;
                  r_state     <= S_BREAK;
               end
            end
            S_BREAK: begin
               if (w_rx_s) r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // A full FIFO still accepts a push when the head is popped in the same cycle.
   assign w_full = (r_count == CNT_MAX);
   assign w_pop  = rx_pop && (r_count != '0);
   assign w_wr   = r_push && (!w_full || w_pop);

   // NOTE: the storage array carries no reset; occupancy and pointers alone
   // decide what is visible, so stale contents are never observed.
   always_ff @(posedge CLK) begin
      if (w_wr) r_mem[r_wr_ptr] <= r_push_data;
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
         r_overrun <= 1'b0;
      end else begin
         if (w_wr)  r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
         if (w_wr && !w_pop)      r_count <= r_count + 1'b1;
         else if (!w_wr && w_pop) r_count <= r_count - 1'b1;
         if (r_push && w_full && !w_pop) r_overrun <= 1'b1;
         else if (clr_err)               r_overrun <= 1'b0;
      end
   end

   assign rx_valid  = (r_count != '0);
   assign rx_data   = rx_valid ? r_mem[r_rd_ptr] : 8'h00;
   assign frame_err = r_frame_err;
   assign overrun   = r_overrun;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed and randomized bench for uart_rx_fifo against a frame-level
// queue model of the receive FIFO and its sticky error flags.
module tb_uart_rx_fifo;

   localparam int CPB   = 16;
   localparam int FW    = 2;
   localparam int DEPTH = 4;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic       UART_RX = 1'b1;
   logic       rx_pop = 1'b0;
   logic       clr_err = 1'b0;
   logic [7:0] rx_data;
   logic       rx_valid, frame_err, overrun;

   int n_checks = 0;
   int n_errors = 0;

   byte unsigned model_q[$];
   bit           m_ferr = 1'b0;
   bit           m_ovr  = 1'b0;

   uart_rx_fifo #(.CLK_PER_BIT(CPB), .FIFO_WIDTH(FW)) dut (
      .CLK(CLK), .RST(RST), .UART_RX(UART_RX),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_pop(rx_pop),
      .frame_err(frame_err), .overrun(overrun), .clr_err(clr_err)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog expired");
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge CLK);
         #1;
      end
   endtask

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      logic [7:0] exp_data;
      exp_data = (model_q.size() != 0) ? model_q[0] : 8'h00;
      check({tag, ".valid"}, {7'd0, rx_valid}, {7'd0, model_q.size() != 0});
      check({tag, ".data"}, rx_data, exp_data);
      check({tag, ".frame_err"}, {7'd0, frame_err}, {7'd0, m_ferr});
      check({tag, ".overrun"}, {7'd0, overrun}, {7'd0, m_ovr});
   endtask

   // Line stays at the stop-bit level afterwards; a bad stop leaves it low.
   task automatic send_byte(input logic [7:0] d, input bit stop_ok);
      logic [9:0] frame;
      frame = {stop_ok, d, 1'b0};
      for (int i = 0; i < 10; i++) begin
         UART_RX = frame[i];
         tick(CPB);
      end
      if (!stop_ok)                     m_ferr = 1'b1;
      else if (model_q.size() < DEPTH)  model_q.push_back(d);
      else                              m_ovr = 1'b1;
   endtask

   task automatic pop_one(input string tag);
      check_state(tag);
      rx_pop = 1'b1;
      tick(1);
      rx_pop = 1'b0;
      if (model_q.size() != 0) void'(model_q.pop_front());
   endtask

   task automatic clear_errors();
      clr_err = 1'b1;
      tick(1);
      clr_err = 1'b0;
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   task automatic do_reset(input int n);
      RST     = 1'b1;
      UART_RX = 1'b1;
      tick(n);
      RST = 1'b0;
      model_q.delete();
      m_ferr = 1'b0;
      m_ovr  = 1'b0;
   endtask

   initial begin
      logic [7:0] d;
      bit         ok;

      do_reset(4);
      check_state("reset");
      tick(5);

      // Single byte, then pop empties the FIFO
      send_byte(8'hA5, 1'b1);
      check_state("t1.rx");
      pop_one("t1.pop");
      check_state("t1.empty");

      // Back-to-back frames with no idle gap
      send_byte(8'h00, 1'b1);
      send_byte(8'hFF, 1'b1);
      send_byte(8'h3C, 1'b1);
      for (int i = 0; i < 3; i++) pop_one("t2.pop");
      check_state("t2.empty");

      // Fifth byte overflows a four-entry FIFO
      for (int i = 1; i <= 5; i++) send_byte(8'(i), 1'b1);
      check_state("t3.full");
      for (int i = 0; i < 4; i++) pop_one("t3.drain");
      clear_errors();
      check_state("t3.clr");

      // Framing error, long break, then recovery
      send_byte(8'h55, 1'b0);
      tick(40);
      check_state("t4.ferr");
      UART_RX = 1'b1;
      tick(20);
      send_byte(8'h12, 1'b1);
      check_state("t4.rx");
      pop_one("t4.pop");
      clear_errors();
      check_state("t4.clr");

      // Short low glitch on idle line is ignored
      UART_RX = 1'b0;
      tick(4);
      UART_RX = 1'b1;
      tick(40);
      check_state("t5.glitch");

      // Reset in the middle of a frame abandons it and empties the FIFO
      send_byte(8'h99, 1'b1);
      UART_RX = 1'b0;
      tick(CPB);
      for (int i = 0; i < 3; i++) begin
         UART_RX = (8'hC3 >> i) & 8'h01;
         tick(CPB);
      end
      do_reset(3);
      check_state("t6.reset");
      tick(20);
      send_byte(8'h7E, 1'b1);
      check_state("t6.rx");
      pop_one("t6.pop");

      // Randomized traffic with occasional bad stop bits, gaps, pops and clears
      for (int it = 0; it < 24; it++) begin
         d  = 8'($urandom);
         ok = ($urandom_range(0, 9) != 0);
         send_byte(d, ok);
         if (!ok) begin
            tick(5);
            UART_RX = 1'b1;
            tick(CPB);
         end
         if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 20));
         repeat ($urandom_range(0, 2)) pop_one("rnd.pop");
         if ($urandom_range(0, 5) == 0) clear_errors();
         check_state("rnd.state");
      end
      while (model_q.size() != 0) pop_one("rnd.drain");
      check_state("rnd.empty");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
